qkv_proj_sched: RTL and testbench

Sequencer for the Q/K/V projection unit. It accepts a command to project a sequence of token vectors and drives the unit's start and in_valid strobes once per token. It waits for the unit's out_valid, then presents each Q/K/V result downstream with a token index under a valid/ready handshake. It sits between the token buffer (upstream) and the attention-score stage (downstream). A watchdog aborts the sequence if the projection unit hangs.

---
 rtl/qkv_proj_sched_if.sv | 32 +++
 rtl/qkv_proj_sched.sv | 130 +++++++++++++
 tb/tb_qkv_proj_sched.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qkv_proj_sched_if.sv
// Handshake bundle between the Q/K/V projection sequencer and its neighbours.
// The master modport is the sequencer; the slave modport is the surrounding environment.
interface qkv_proj_sched_if #(
    parameter int LW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len;
    logic          tok_valid;
    logic          tok_ready;
    logic          proj_start;
    logic          proj_in_valid;
    logic          proj_out_valid;
    logic          res_valid;
    logic          res_ready;
    logic [LW-1:0] res_idx;
    logic          busy;
    logic          done;
    logic          err_timeout;

    modport master (
        input  cmd_valid, cmd_len, tok_valid, proj_out_valid, res_ready,
        output cmd_ready, tok_ready, proj_start, proj_in_valid, res_valid,
               res_idx, busy, done, err_timeout
    );

    modport slave (
        output cmd_valid, cmd_len, tok_valid, proj_out_valid, res_ready,
        input  cmd_ready, tok_ready, proj_start, proj_in_valid, res_valid,
               res_idx, busy, done, err_timeout
    );
endinterface

// File: rtl/qkv_proj_sched.sv
// Q/K/V projection sequencer: one token in flight at a time, start/feed/wait/emit per token,
// with a watchdog on the projection unit's out_valid.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready high
// S_START | one-cycle proj_start pulse for token idx
// S_FEED  | tok_ready high, proj_in_valid follows tok_valid
// S_WAIT  | waiting for proj_out_valid, watchdog timer running
// S_EMIT  | result for token idx presented downstream until res_ready
// S_DONE  | one-cycle done pulse, normal end or watchdog abort
module qkv_proj_sched #(
    parameter int MAX_LEN = 128,
    parameter int LW      = $clog2(MAX_LEN + 1),
    parameter int TIMEOUT = 1024,
    parameter int TW      = $clog2(TIMEOUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    qkv_proj_sched_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [LW-1:0] MAX_LEN_W  = LW'(MAX_LEN);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [LW-1:0] idx, idx_nxt;
    logic [LW-1:0] len, len_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          err, err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            len   <= '0;
            timer <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            len   <= len_nxt;
            timer <= timer_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        len_nxt   = len;
        timer_nxt = timer;
        err_nxt   = err;

        bus.cmd_ready     = 1'b0;
        bus.tok_ready     = 1'b0;
        bus.proj_start    = 1'b0;
        bus.proj_in_valid = 1'b0;
        bus.res_valid     = 1'b0;
        bus.res_idx       = '0;
        bus.busy          = 1'b1;
        bus.done          = 1'b0;
        bus.err_timeout   = err;

        case (state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    len_nxt   = (bus.cmd_len > MAX_LEN_W) ? MAX_LEN_W : bus.cmd_len;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = (bus.cmd_len == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                bus.proj_start = 1'b1;
                state_nxt      = S_FEED;
            end
            S_FEED: begin
                bus.tok_ready     = 1'b1;
                bus.proj_in_valid = bus.tok_valid;
                if (bus.tok_valid) begin
                    timer_nxt = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle still counts as on time.
                if (bus.proj_out_valid) begin
                    state_nxt = S_EMIT;
                end else if (timer == TIMER_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_EMIT: begin
                bus.res_valid = 1'b1;
                bus.res_idx   = idx;
                if (bus.res_ready) begin
                    if (idx == len - LW'(1)) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx + LW'(1);
                        state_nxt = S_START;
                    end
                end
            end
            S_DONE: begin
                bus.done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qkv_proj_sched.sv
// Bench for qkv_proj_sched: table of directed sequences plus randomized delay sequences,
// checked against a transaction-level latency/result model.
module tb_qkv_proj_sched;
    localparam int MAX_LEN = 128;
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qkv_proj_sched_if #(.LW(LW)) bus ();

    qkv_proj_sched #(
        .MAX_LEN(MAX_LEN),
        .LW(LW),
        .TIMEOUT(TIMEOUT),
        .TW($clog2(TIMEOUT))
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // per-token environment delays: FEED stall, WAIT cycle of out_valid, EMIT stall
    int dt[MAX_LEN];
    int dp[MAX_LEN];
    int dr[MAX_LEN];

    typedef struct {
        int len;
        int dt;
        int dp;
        int dr;
        bit spur;
        int abort_tok;
        int exp_lat;
        int exp_emits;
        bit exp_err;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycles from accept to done, results delivered, starts issued, watchdog outcome.
    function automatic void model(input int len, output int lat, output int emits,
                                  output int starts, output bit err);
        int n;
        n      = (len > MAX_LEN) ? MAX_LEN : len;
        lat    = 1;
        emits  = 0;
        starts = 0;
        err    = 1'b0;
        for (int k = 0; k < n; k++) begin
            starts++;
            lat += 1 + (dt[k] + 1);
            if (dp[k] >= TIMEOUT) begin
                lat += TIMEOUT;
                err = 1'b1;
                return;
            end
            lat += (dp[k] + 1) + (dr[k] + 1);
            emits++;
        end
    endfunction

    task automatic run_seq(input int len, input bit spur, input int abort_tok,
                           output int lat, output int emits, output int starts,
                           output bit err_seen, output bit aborted);
        int cyc, k, feed_cnt, wait_cnt, emit_cnt, starts_l, hs;
        bit in_wait, got_done;
        cyc = 0; k = 0; feed_cnt = 0; wait_cnt = 0; emit_cnt = 0;
        starts_l = 0; hs = 0; in_wait = 0; got_done = 0;
        lat = -1; err_seen = 0; aborted = 0;

        @(negedge clk);
        chk("cmd_ready_before_accept", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        @(posedge clk);

        while (!got_done && !aborted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus.cmd_valid      = spur;
            bus.cmd_len        = LW'($urandom_range(0, 5));
            bus.tok_valid      = 1'b0;
            bus.proj_out_valid = 1'b0;
            bus.res_ready      = 1'b0;
            if (cyc == 1) chk("err_clear_on_accept", bus.err_timeout, 0);
            if (bus.done) begin
                got_done      = 1;
                lat           = cyc;
                err_seen      = bus.err_timeout;
                bus.cmd_valid = 1'b0;
            end else begin
                chk("busy_in_seq", bus.busy, 1);
                chk("cmd_ready_in_seq", bus.cmd_ready, 0);
                if (bus.proj_start) begin
                    chk("start_only_after_handshake", starts_l, hs);
                    starts_l++;
                    feed_cnt = 0;
                    if (spur) bus.proj_out_valid = 1'($urandom_range(0, 1));
                end else if (bus.tok_ready) begin
                    bus.tok_valid = (feed_cnt >= dt[k]);
                    if (spur) bus.proj_out_valid = 1'($urandom_range(0, 1));
                    #1;
                    chk("proj_in_valid", bus.proj_in_valid, bus.tok_valid);
                    feed_cnt++;
                    if (bus.tok_valid) begin
                        in_wait  = 1;
                        wait_cnt = 0;
                    end
                end else if (bus.res_valid) begin
                    in_wait = 0;
                    chk("res_idx", bus.res_idx, k);
                    bus.res_ready = (emit_cnt >= dr[k]);
                    if (spur) bus.proj_out_valid = 1'($urandom_range(0, 1));
                    emit_cnt++;
                    if (bus.res_ready) begin
                        hs++;
                        k++;
                        emit_cnt = 0;
                    end
                end else if (in_wait) begin
                    if (abort_tok == k && wait_cnt == 2) begin
                        rst           = 1'b1;
                        bus.tok_valid = 1'b1;
                        #1;
                        chk("abort_cmd_ready", bus.cmd_ready, 1);
                        chk("abort_busy", bus.busy, 0);
                        chk("abort_done", bus.done, 0);
                        chk("abort_proj_start", bus.proj_start, 0);
                        chk("abort_proj_in_valid", bus.proj_in_valid, 0);
                        chk("abort_tok_ready", bus.tok_ready, 0);
                        chk("abort_res_valid", bus.res_valid, 0);
                        chk("abort_res_idx", bus.res_idx, 0);
                        chk("abort_err", bus.err_timeout, 0);
                        bus.tok_valid = 1'b0;
                        bus.cmd_valid = 1'b0;
                        @(negedge clk);
                        rst = 1'b0;
                        for (int i = 0; i < 4; i++) begin
                            @(negedge clk);
                            chk("no_done_after_abort", bus.done, 0);
                            chk("idle_after_abort", bus.busy, 0);
                        end
                        aborted = 1;
                    end else begin
                        bus.proj_out_valid = (wait_cnt == dp[k]);
                        wait_cnt++;
                    end
                end else begin
                    errors++;
                    $display("FAIL seq_state: got no recognisable phase expected START/FEED/WAIT/EMIT at cycle %0d", cyc);
                end
            end
            if (!got_done && !aborted) @(posedge clk);
        end
        if (!got_done && !aborted) begin
            errors++;
            $display("FAIL seq_timeout: got no done expected done within 3000 cycles");
        end
        bus.cmd_valid      = 1'b0;
        bus.tok_valid      = 1'b0;
        bus.proj_out_valid = 1'b0;
        bus.res_ready      = 1'b0;
        emits  = hs;
        starts = starts_l;
    endtask

    task automatic check_seq(input string tag, input int len, input bit spur, input int abort_tok,
                             input int exp_lat, input int exp_emits, input bit exp_err);
        int lat, emits, starts;
        bit err_seen, aborted;
        run_seq(len, spur, abort_tok, lat, emits, starts, err_seen, aborted);
        if (abort_tok >= 0) begin
            chk({tag, "_aborted"}, aborted, 1);
            return;
        end
        chk({tag, "_done_latency"}, lat, exp_lat);
        chk({tag, "_results"}, emits, exp_emits);
        chk({tag, "_starts"}, starts, exp_emits + int'(exp_err));
        chk({tag, "_err_at_done"}, err_seen, exp_err);
        @(negedge clk);
        chk({tag, "_idle_busy"}, bus.busy, 0);
        chk({tag, "_idle_cmd_ready"}, bus.cmd_ready, 1);
        chk({tag, "_idle_done"}, bus.done, 0);
        chk({tag, "_err_sticky"}, bus.err_timeout, exp_err);
    endtask

    initial begin
        int lat, emits, starts;
        bit err;

        //            len  dt dp  dr spur abort lat emits err
        tbl[0] = '{  3,  0, 0,  0, 0,  -1,  13,   3, 0};
        tbl[1] = '{  0,  0, 0,  0, 0,  -1,   1,   0, 0};
        tbl[2] = '{  2,  5, 0,  7, 0,  -1,  33,   2, 0};
        tbl[3] = '{  1,  0, 20, 0, 0,  -1,  19,   0, 1};
        tbl[4] = '{  1,  0, 0,  0, 0,  -1,   5,   1, 0};
        tbl[5] = '{  1,  0, 15, 0, 0,  -1,  20,   1, 0};
        tbl[6] = '{  3,  2, 3,  1, 1,  -1,  31,   3, 0};
        tbl[7] = '{  4,  0, 5,  0, 0,   1,  -1,   0, 0};
        tbl[8] = '{  1,  0, 0,  0, 0,  -1,   5,   1, 0};
        tbl[9] = '{200,  0, 0,  0, 0,  -1, 513, 128, 0};

        rst                = 1'b1;
        bus.cmd_valid      = 1'b0;
        bus.cmd_len        = '0;
        bus.tok_valid      = 1'b0;
        bus.proj_out_valid = 1'b0;
        bus.res_ready      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_proj_start", bus.proj_start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_err", bus.err_timeout, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            for (int t = 0; t < MAX_LEN; t++) begin
                dt[t] = tbl[i].dt;
                dp[t] = tbl[i].dp;
                dr[t] = tbl[i].dr;
            end
            check_seq($sformatf("vec%0d", i), tbl[i].len, tbl[i].spur, tbl[i].abort_tok,
                      tbl[i].exp_lat, tbl[i].exp_emits, tbl[i].exp_err);
        end

        for (int r = 0; r < 25; r++) begin
            int len;
            bit spur;
            len  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            spur = 1'($urandom_range(0, 1));
            for (int t = 0; t < MAX_LEN; t++) begin
                dt[t] = int'($urandom_range(0, 3));
                dp[t] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 20))
                                                    : int'($urandom_range(0, 4));
                dr[t] = int'($urandom_range(0, 3));
            end
            model(len, lat, emits, starts, err);
            check_seq($sformatf("rnd%0d", r), len, spur, -1, lat, emits, err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
